// File: rtl/bcd_to_bin_seq_if.sv
// Start/done handshake bundle for the packed-BCD to binary converter.
// master drives the request side, slave is the converter.
interface bcd_to_bin_seq_if #(
   parameter int unsigned DIGITS = 2,
   parameter int unsigned BIN_W  = 7
);

   logic                  start;
   logic [4*DIGITS-1:0]   bcd_in;
   logic                  busy;
   logic                  done;
   logic [BIN_W-1:0]      bin;
   logic                  err;

   modport master (
      output start,
      output bcd_in,
      input  busy,
      input  done,
      input  bin,
      input  err
   );

   modport slave (
      input  start,
      input  bcd_in,
      output busy,
      output done,
      output bin,
      output err
   );

endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit per clock).
// Define BCD_ERR_CHECK_EN to flag digits > 9 on err and skip the shift phase.
module bcd_to_bin_seq #(
   parameter int unsigned DIGITS = 2,
   parameter int unsigned BIN_W  = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   bcd_to_bin_seq_if.slave  bus
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StShift = 2'd1;
   localparam logic [1:0] StFin   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic [BIN_W-1:0] acc_q, acc_d;
   logic [BIN_W-1:0] bin_q, bin_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [BCD_W-1:0] bcd_shift;
   logic [BCD_W-1:0] bcd_corr;
   logic [BIN_W-1:0] acc_shift;
   logic             last_shift;

   // One reverse double-dabble step: shift {bcd, acc} right, then -3 on digits >= 8.
   always_comb begin
      bcd_shift = bcd_q >> 1;
      acc_shift = {bcd_q[0], acc_q[BIN_W-1:1]};
      bcd_corr  = bcd_shift;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (bcd_shift[4*i +: 4] >= 4'd8) begin
            bcd_corr[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
         end
      end
   end

   assign last_shift = (cnt_q == CNT_W'(BIN_W - 1));

`ifdef BCD_ERR_CHECK_EN
   logic err_q, err_d;
   logic bad_digit;

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (bus.bcd_in[4*i +: 4] > 4'd9) begin
            bad_digit = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      acc_d   = acc_q;
      bin_d   = bin_q;
      cnt_d   = cnt_q;
`ifdef BCD_ERR_CHECK_EN
      err_d   = err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               bcd_d   = bus.bcd_in;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = StShift;
`ifdef BCD_ERR_CHECK_EN
               err_d   = 1'b0;
               if (bad_digit) begin
                  err_d   = 1'b1;
                  bin_d   = '0;
                  bcd_d   = '0;
                  state_d = StFin;
               end
`endif
            end
         end
         StShift: begin
            bcd_d = bcd_corr;
            acc_d = acc_shift;
            cnt_d = cnt_q + 1'b1;
            if (last_shift) begin
               // Capture the final accumulator here so bin is valid during the FIN cycle.
               bin_d   = acc_shift;
               state_d = StFin;
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         bcd_q   <= '0;
         acc_q   <= '0;
         bin_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         acc_q   <= acc_d;
         bin_q   <= bin_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef BCD_ERR_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.busy = (state_q == StShift);
   assign bus.done = (state_q == StFin);
   assign bus.bin  = bin_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: scoreboard of expected results popped on each done.
module tb_bcd_to_bin_seq;

   localparam int unsigned DIGITS = 2;
   localparam int unsigned BIN_W  = 7;

   typedef struct packed {
      logic             err;
      logic [BIN_W-1:0] bin;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;
   int   cyc;
   int   done_cnt;
   int   wide_cnt;
   logic done_prev;
   exp_t exp_q[$];

   bcd_to_bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

   bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         done_cnt++;
         if (done_prev) wide_cnt++;
      end
      done_prev = (bus.done === 1'b1);
   end

   task automatic wait_done(output int cycles, output bit seen);
      seen   = 1'b0;
      cycles = 0;
      while (!seen && cycles < 40) begin
         @(negedge clk);
         cycles++;
         if (bus.done === 1'b1) seen = 1'b1;
      end
   endtask

   // Presents one request; returns just after the edge that samples it.
   task automatic load(input logic [7:0] v);
      bus.start  = 1'b1;
      bus.bcd_in = v;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #3;
      n_cmp++;
      if ({bus.busy, bus.done, bus.bin, bus.err} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%b done=%b bin=%0d err=%b, required all 0",
                  bus.busy, bus.done, bus.bin, bus.err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single;
      exp_t e;
      load(8'h99);
      exp_q.push_back('{err: 1'b0, bin: 7'd99});
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy cycle %0d: busy=%b done=%b, required busy=1 done=0",
                     i, bus.busy, bus.done);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done cycle 8: done=%b busy=%b, required done=1 busy=0",
                  bus.done, bus.busy);
      end
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL single_scoreboard: queue empty, required one entry");
      end else begin
         e = exp_q.pop_front();
         n_cmp++;
         if (bus.bin !== e.bin || bus.err !== e.err) begin
            n_fail++;
            $display("FAIL single_result: bin=%0d err=%b, required bin=%0d err=%b",
                     bus.bin, bus.err, e.bin, e.err);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done_width: done=%b one cycle later, required 0", bus.done);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] vals [3];
      int   cycles;
      bit   seen;
      int   last_cyc;
      int   wide_before;
      exp_t e;
      vals[0] = 8'h00;
      vals[1] = 8'h47;
      vals[2] = 8'h10;
      wide_before = wide_cnt;
      last_cyc = 0;
      @(posedge clk);
      #1;
      bus.start  = 1'b1;
      bus.bcd_in = vals[0];
      exp_q.push_back('{err: 1'b0, bin: 7'd0});
      @(posedge clk);
      #1;
      bus.bcd_in = vals[1];
      exp_q.push_back('{err: 1'b0, bin: 7'd47});
      for (int k = 0; k < 3; k++) begin
         wait_done(cycles, seen);
         n_cmp++;
         if (!seen) begin
            n_fail++;
            $display("FAIL b2b_timeout %0d: no done within %0d cycles", k, cycles);
         end else begin
            if (k == 2) bus.start = 1'b0;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL b2b_scoreboard %0d: queue empty", k);
            end else begin
               e = exp_q.pop_front();
               if (bus.bin !== e.bin || bus.err !== e.err) begin
                  n_fail++;
                  $display("FAIL b2b_result %0d: bin=%0d err=%b, required bin=%0d err=%b",
                           k, bus.bin, bus.err, e.bin, e.err);
               end
            end
            if (k > 0) begin
               n_cmp++;
               if (cyc - last_cyc != int'(BIN_W) + 2) begin
                  n_fail++;
                  $display("FAIL b2b_spacing %0d: %0d cycles between dones, required %0d",
                           k, cyc - last_cyc, BIN_W + 2);
               end
            end
            last_cyc = cyc;
         end
         if (k == 0) begin
            // Next load edge is two edges after the FIN sample point.
            @(posedge clk);
            @(posedge clk);
            #1;
            bus.bcd_in = vals[2];
            exp_q.push_back('{err: 1'b0, bin: 7'd10});
         end
      end
      @(negedge clk);
      n_cmp++;
      if (wide_cnt != wide_before) begin
         n_fail++;
         $display("FAIL b2b_done_width: %0d wide done pulses, required 0", wide_cnt - wide_before);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_ignore_start;
      int   cycles;
      bit   seen;
      int   dc;
      exp_t e;
      load(8'h25);
      exp_q.push_back('{err: 1'b0, bin: 7'd25});
      dc = done_cnt;
      repeat (3) @(posedge clk);
      #1;
      bus.start  = 1'b1;
      bus.bcd_in = 8'h88;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(cycles, seen);
      n_cmp++;
      if (!seen || cycles != 4) begin
         n_fail++;
         $display("FAIL ignore_latency: seen=%b after %0d cycles, required done after 4",
                  seen, cycles);
      end
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL ignore_scoreboard: queue empty");
      end else begin
         e = exp_q.pop_front();
         n_cmp++;
         if (bus.bin !== e.bin || bus.err !== e.err) begin
            n_fail++;
            $display("FAIL ignore_result: bin=%0d err=%b, required bin=%0d err=%b",
                     bus.bin, bus.err, e.bin, e.err);
         end
      end
      repeat (12) @(negedge clk);
      n_cmp++;
      if (done_cnt - dc != 1) begin
         n_fail++;
         $display("FAIL ignore_single_done: %0d done pulses, required 1", done_cnt - dc);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid;
      int   cycles;
      bit   seen;
      int   dc;
      exp_t e;
      load(8'h63);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.busy, bus.done, bus.bin, bus.err} !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs: busy=%b done=%b bin=%0d err=%b, required all 0",
                  bus.busy, bus.done, bus.bin, bus.err);
      end
      dc = done_cnt;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      n_cmp++;
      if (done_cnt != dc) begin
         n_fail++;
         $display("FAIL midreset_no_done: %0d done pulses after abort, required 0", done_cnt - dc);
      end
      @(posedge clk);
      #1;
      load(8'h63);
      exp_q.push_back('{err: 1'b0, bin: 7'd63});
      wait_done(cycles, seen);
      n_cmp++;
      if (!seen || cycles != 8) begin
         n_fail++;
         $display("FAIL midreset_latency: seen=%b after %0d cycles, required 8", seen, cycles);
      end
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL midreset_scoreboard: queue empty");
      end else begin
         e = exp_q.pop_front();
         n_cmp++;
         if (bus.bin !== e.bin || bus.err !== e.err) begin
            n_fail++;
            $display("FAIL midreset_result: bin=%0d err=%b, required bin=%0d err=%b",
                     bus.bin, bus.err, e.bin, e.err);
         end
      end
      @(posedge clk);
      #1;
   endtask

`ifdef BCD_ERR_CHECK_EN
   task automatic test_err_check;
      int   cycles;
      bit   seen;
      exp_t e;
      logic [7:0] vals [2];
      int   lat [2];
      vals[0] = 8'h3A;
      vals[1] = 8'h12;
      lat[0]  = 1;
      lat[1]  = 8;
      for (int k = 0; k < 2; k++) begin
         load(vals[k]);
         if (k == 0) exp_q.push_back('{err: 1'b1, bin: 7'd0});
         else        exp_q.push_back('{err: 1'b0, bin: 7'd12});
         wait_done(cycles, seen);
         n_cmp++;
         if (!seen || cycles != lat[k]) begin
            n_fail++;
            $display("FAIL err_latency %0d: seen=%b after %0d cycles, required %0d",
                     k, seen, cycles, lat[k]);
         end
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL err_scoreboard %0d: queue empty", k);
         end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.bin !== e.bin || bus.err !== e.err) begin
               n_fail++;
               $display("FAIL err_result %0d: bin=%0d err=%b, required bin=%0d err=%b",
                        k, bus.bin, bus.err, e.bin, e.err);
            end
         end
         @(posedge clk);
         #1;
      end
   endtask
`endif

   task automatic test_sweep;
      int   cycles;
      bit   seen;
      exp_t e;
      for (int d = 0; d < 100; d++) begin
         load({4'(d / 10), 4'(d % 10)});
         exp_q.push_back('{err: 1'b0, bin: 7'(d)});
         wait_done(cycles, seen);
         n_cmp++;
         if (!seen || cycles != 8) begin
            n_fail++;
            $display("FAIL sweep_latency %0d: seen=%b after %0d cycles, required 8",
                     d, seen, cycles);
         end
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sweep_scoreboard %0d: queue empty", d);
         end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.bin !== e.bin || bus.err !== e.err) begin
               n_fail++;
               $display("FAIL sweep_result %0d: bin=%0d err=%b, required bin=%0d err=%b",
                        d, bus.bin, bus.err, e.bin, e.err);
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      n_cmp      = 0;
      n_fail     = 0;
      cyc        = 0;
      done_cnt   = 0;
      wide_cnt   = 0;
      done_prev  = 1'b0;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.bcd_in = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_ignore_start();
      test_reset_mid();
`ifdef BCD_ERR_CHECK_EN
      test_err_check();
`endif
      test_sweep();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
